// File: rtl/reorder_buffer_pkg.sv
// Shared types and helpers for the reorder buffer and its retire selector.
package reorder_buffer_pkg;

    localparam int XLEN         = 32;
    localparam int PRF          = 64;
    localparam int PRF_W        = $clog2(PRF);
    localparam int DEF_ROB_SIZE = 32;

    // One in-flight instruction as seen by retire.
    typedef struct packed {
        logic             valid;
        logic             done;
        logic [4:0]       dest_arn;
        logic [PRF_W-1:0] dest_prn;
        logic             reg_write;
        logic [XLEN-1:0]  pc;
        logic             is_branch;
        logic             pred_taken;
        logic [XLEN-1:0]  pred_target;
        logic             taken;
        logic [XLEN-1:0]  target;
        logic             halt;
    } rob_entry_t;

    // A branch mispredicts on a wrong direction, or on a wrong target when taken.
    function automatic logic is_mispredict(input rob_entry_t e);
        return e.is_branch &
               ((e.pred_taken != e.taken) | (e.taken & (e.pred_target != e.target)));
    endfunction

    // Where fetch must restart after a mispredicted branch retires.
    function automatic logic [XLEN-1:0] redirect_pc(input rob_entry_t e);
        return e.taken ? e.target : e.pc + XLEN'(4);
    endfunction

endpackage

// File: rtl/reorder_buffer_retire_select.sv
// Decides which of the two oldest entries retire this cycle.
module reorder_buffer_retire_select
    import reorder_buffer_pkg::*;
#(
    parameter int CNT_W = 6
) (
    input  rob_entry_t       head0,
    input  rob_entry_t       head1,
    input  logic [CNT_W-1:0] count,
    input  logic             halted,
    output logic [1:0]       retire,
    output logic [1:0]       mispredict,
    output logic [1:0]       halt
);

    // Lane1 may only follow a lane0 that neither redirects nor halts the machine.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        retire     = 2'b00;
        mispredict = 2'b00;
        halt       = 2'b00;

        retire[0] = (count != '0) && head0.done && !halted;
        retire[1] = retire[0] && head1.valid && head1.done &&
                    !is_mispredict(head0) && !head0.halt;

        mispredict[0] = retire[0] & is_mispredict(head0);
        mispredict[1] = retire[1] & is_mispredict(head1);
        halt[0]       = retire[0] & head0.halt;
        halt[1]       = retire[1] & head1.halt;
    end

endmodule

// File: rtl/reorder_buffer.sv
// 2-wide in-order reorder buffer: dispatch allocation, completion marking,
// in-order retire with predictor update, squash on mispredict and halt.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_SIZE = DEF_ROB_SIZE,
    parameter int ROB_W    = $clog2(ROB_SIZE)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            dispatch_valid,
    input  logic [1:0][4:0]       dispatch_dest_arn,
    input  logic [1:0][PRF_W-1:0] dispatch_dest_prn,
    input  logic [1:0]            dispatch_reg_write,
    input  logic [1:0][XLEN-1:0]  dispatch_PC,
    input  logic [1:0]            dispatch_is_branch,
    input  logic [1:0]            dispatch_pred_taken,
    input  logic [1:0][XLEN-1:0]  dispatch_pred_target,
    input  logic [1:0]            dispatch_halt,
    output logic                  dispatch_ready,
    output logic [1:0][ROB_W-1:0] dispatch_rob_idx,
    input  logic [1:0]            complete_valid,
    input  logic [1:0][ROB_W-1:0] complete_rob_idx,
    input  logic [1:0]            complete_taken,
    input  logic [1:0][XLEN-1:0]  complete_target,
    output logic [1:0]            rob_retire,
    output logic [1:0][4:0]       ARCH_ARF_idx,
    output logic [1:0][PRF_W-1:0] ARCH_PRF_idx,
    output logic [1:0][PRF_W-1:0] dest_PRN_out,
    output logic [1:0]            retired,
    output logic [1:0][XLEN-1:0]  PC_update,
    output logic [1:0]            direction_update,
    output logic [1:0][XLEN-1:0]  target_update,
    output logic [1:0]            valid_update,
    output logic                  squash,
    output logic [XLEN-1:0]       squash_PC,
    output logic                  halt_out,
    output logic                  rob_empty
);

    localparam int              CNT_W  = ROB_W + 1;
    localparam logic [CNT_W-1:0] SIZE_C = CNT_W'(ROB_SIZE);

    rob_entry_t            mem [ROB_SIZE];
    logic [ROB_SIZE-1:0]   valid_q, done_q, valid_n, done_n;
    logic [ROB_W-1:0]      head, tail, head1, tail1;
    logic [CNT_W-1:0]      count;
    logic [1:0]            disp_acc, ret, mp, hl;
    logic [ROB_W-1:0]      head_step, tail_step;
    logic                  do_squash;
    logic [XLEN-1:0]       redirect;
    rob_entry_t            head_e [2];
    rob_entry_t            disp_e [2];

    assign head1 = head + ROB_W'(1);
    assign tail1 = tail + ROB_W'(1);

    // Free space is judged on the pre-retire count, so a full ROB stays closed this cycle.
    assign dispatch_ready   = ((SIZE_C - count) >= CNT_W'(2)) && !squash && !halt_out;
    assign disp_acc[0]      = dispatch_ready & dispatch_valid[0];
    assign disp_acc[1]      = disp_acc[0] & dispatch_valid[1];
    assign dispatch_rob_idx = {tail1, tail};
    assign rob_empty        = (count == '0);

    assign head_step = ROB_W'(ret[0]) + ROB_W'(ret[1]);
    assign tail_step = ROB_W'(disp_acc[0]) + ROB_W'(disp_acc[1]);
    assign do_squash = |mp;
    assign redirect  = mp[0] ? redirect_pc(head_e[0]) : redirect_pc(head_e[1]);

    // View of the two oldest entries with live valid/done bits merged in.
    always_comb begin
        head_e[0]       = mem[head];
        head_e[0].valid = valid_q[head];
        head_e[0].done  = done_q[head];
        head_e[1]       = mem[head1];
        head_e[1].valid = valid_q[head1];
        head_e[1].done  = done_q[head1];
    end

    // Pack each dispatch lane into an entry image.
    always_comb begin
        for (int l = 0; l < 2; l++) begin
            disp_e[l].valid       = 1'b1;
            disp_e[l].done        = 1'b0;
            disp_e[l].dest_arn    = dispatch_dest_arn[l];
            disp_e[l].dest_prn    = dispatch_dest_prn[l];
            disp_e[l].reg_write   = dispatch_reg_write[l];
            disp_e[l].pc          = dispatch_PC[l];
            disp_e[l].is_branch   = dispatch_is_branch[l];
            disp_e[l].pred_taken  = dispatch_pred_taken[l];
            disp_e[l].pred_target = dispatch_pred_target[l];
            disp_e[l].taken       = 1'b0;
            disp_e[l].target      = '0;
            disp_e[l].halt        = dispatch_halt[l];
        end
    end

    reorder_buffer_retire_select #(
        .CNT_W (CNT_W)
    ) u_retire_select (
        .head0      (head_e[0]),
        .head1      (head_e[1]),
        .count      (count),
        .halted     (halt_out),
        .retire     (ret),
        .mispredict (mp),
        .halt       (hl)
    );

    // Next valid/done: completion sets done, retire frees the head, dispatch claims the tail.
    always_comb begin
        valid_n = valid_q;
        done_n  = done_q;
        for (int l = 0; l < 2; l++) begin
            if (complete_valid[l] && !squash && valid_q[complete_rob_idx[l]]) begin
                done_n[complete_rob_idx[l]] = 1'b1;
            end
        end
        if (ret[0]) begin
            valid_n[head] = 1'b0;
            done_n[head]  = 1'b0;
        end
        if (ret[1]) begin
            valid_n[head1] = 1'b0;
            done_n[head1]  = 1'b0;
        end
        if (disp_acc[0]) begin
            valid_n[tail] = 1'b1;
            done_n[tail]  = 1'b0;
        end
        if (disp_acc[1]) begin
            valid_n[tail1] = 1'b1;
            done_n[tail1]  = 1'b0;
        end
    end

    // Entry payload storage: written on dispatch, branch outcome filled in on completion.
    // NOTE: the payload array has no reset; valid/done gate every read, so clearing it would only cost logic.
    always_ff @(posedge clock) begin
        if (disp_acc[0]) mem[tail]  <= disp_e[0];
        if (disp_acc[1]) mem[tail1] <= disp_e[1];
        for (int l = 0; l < 2; l++) begin
            if (complete_valid[l] && !squash && valid_q[complete_rob_idx[l]]) begin
                mem[complete_rob_idx[l]].taken  <= complete_taken[l];
                mem[complete_rob_idx[l]].target <= complete_target[l];
            end
        end
    end

    // Pointer, occupancy, squash and halt state.
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            valid_q   <= '0;
            done_q    <= '0;
            squash    <= 1'b0;
            squash_PC <= '0;
            halt_out  <= 1'b0;
        end else if (do_squash) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            valid_q   <= '0;
            done_q    <= '0;
            squash    <= 1'b1;
            squash_PC <= redirect;
            halt_out  <= halt_out | (|hl);
        end else begin
            head     <= head + head_step;
            tail     <= tail + tail_step;
            count    <= count + CNT_W'(disp_acc[0]) + CNT_W'(disp_acc[1])
                              - CNT_W'(ret[0]) - CNT_W'(ret[1]);
            valid_q  <= valid_n;
            done_q   <= done_n;
            squash   <= 1'b0;
            halt_out <= halt_out | (|hl);
        end
    end

    // Retire-side outputs, forced to zero on lanes that are not retiring.
    always_comb begin
        rob_retire       = ret;
        ARCH_ARF_idx     = '0;
        ARCH_PRF_idx     = '0;
        dest_PRN_out     = '0;
        retired          = '0;
        PC_update        = '0;
        direction_update = '0;
        target_update    = '0;
        valid_update     = '0;
        for (int l = 0; l < 2; l++) begin
            if (ret[l]) begin
                ARCH_ARF_idx[l]     = head_e[l].dest_arn;
                ARCH_PRF_idx[l]     = head_e[l].dest_prn;
                dest_PRN_out[l]     = head_e[l].dest_prn;
                retired[l]          = head_e[l].reg_write;
                PC_update[l]        = head_e[l].pc;
                direction_update[l] = head_e[l].taken;
                target_update[l]    = head_e[l].target;
                valid_update[l]     = head_e[l].is_branch;
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    localparam int ROB_SIZE = 32;
    localparam int ROB_W    = 5;

    logic                  clock = 1'b0;
    logic                  reset;
    logic [1:0]            dispatch_valid;
    logic [1:0][4:0]       dispatch_dest_arn;
    logic [1:0][PRF_W-1:0] dispatch_dest_prn;
    logic [1:0]            dispatch_reg_write;
    logic [1:0][XLEN-1:0]  dispatch_PC;
    logic [1:0]            dispatch_is_branch;
    logic [1:0]            dispatch_pred_taken;
    logic [1:0][XLEN-1:0]  dispatch_pred_target;
    logic [1:0]            dispatch_halt;
    logic                  dispatch_ready;
    logic [1:0][ROB_W-1:0] dispatch_rob_idx;
    logic [1:0]            complete_valid;
    logic [1:0][ROB_W-1:0] complete_rob_idx;
    logic [1:0]            complete_taken;
    logic [1:0][XLEN-1:0]  complete_target;
    logic [1:0]            rob_retire;
    logic [1:0][4:0]       ARCH_ARF_idx;
    logic [1:0][PRF_W-1:0] ARCH_PRF_idx;
    logic [1:0][PRF_W-1:0] dest_PRN_out;
    logic [1:0]            retired;
    logic [1:0][XLEN-1:0]  PC_update;
    logic [1:0]            direction_update;
    logic [1:0][XLEN-1:0]  target_update;
    logic [1:0]            valid_update;
    logic                  squash;
    logic [XLEN-1:0]       squash_PC;
    logic                  halt_out;
    logic                  rob_empty;

    int checks = 0;
    int errors = 0;

    reorder_buffer #(.ROB_SIZE(ROB_SIZE)) dut (
        .clock                (clock),
        .reset                (reset),
        .dispatch_valid       (dispatch_valid),
        .dispatch_dest_arn    (dispatch_dest_arn),
        .dispatch_dest_prn    (dispatch_dest_prn),
        .dispatch_reg_write   (dispatch_reg_write),
        .dispatch_PC          (dispatch_PC),
        .dispatch_is_branch   (dispatch_is_branch),
        .dispatch_pred_taken  (dispatch_pred_taken),
        .dispatch_pred_target (dispatch_pred_target),
        .dispatch_halt        (dispatch_halt),
        .dispatch_ready       (dispatch_ready),
        .dispatch_rob_idx     (dispatch_rob_idx),
        .complete_valid       (complete_valid),
        .complete_rob_idx     (complete_rob_idx),
        .complete_taken       (complete_taken),
        .complete_target      (complete_target),
        .rob_retire           (rob_retire),
        .ARCH_ARF_idx         (ARCH_ARF_idx),
        .ARCH_PRF_idx         (ARCH_PRF_idx),
        .dest_PRN_out         (dest_PRN_out),
        .retired              (retired),
        .PC_update            (PC_update),
        .direction_update     (direction_update),
        .target_update        (target_update),
        .valid_update         (valid_update),
        .squash               (squash),
        .squash_PC            (squash_PC),
        .halt_out             (halt_out),
        .rob_empty            (rob_empty)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        dispatch_valid       = '0;
        dispatch_dest_arn    = '0;
        dispatch_dest_prn    = '0;
        dispatch_reg_write   = '0;
        dispatch_PC          = '0;
        dispatch_is_branch   = '0;
        dispatch_pred_taken  = '0;
        dispatch_pred_target = '0;
        dispatch_halt        = '0;
        complete_valid       = '0;
        complete_rob_idx     = '0;
        complete_taken       = '0;
        complete_target      = '0;
    endtask

    task automatic set_lane(input int l, input logic [4:0] arn, input logic [PRF_W-1:0] prn,
                            input logic rw, input logic [XLEN-1:0] pc, input logic br,
                            input logic pt, input logic [XLEN-1:0] ptgt, input logic h);
        dispatch_valid[l]       = 1'b1;
        dispatch_dest_arn[l]    = arn;
        dispatch_dest_prn[l]    = prn;
        dispatch_reg_write[l]   = rw;
        dispatch_PC[l]          = pc;
        dispatch_is_branch[l]   = br;
        dispatch_pred_taken[l]  = pt;
        dispatch_pred_target[l] = ptgt;
        dispatch_halt[l]        = h;
    endtask

    task automatic set_complete(input int l, input logic [ROB_W-1:0] idx,
                                input logic tk, input logic [XLEN-1:0] tgt);
        complete_valid[l]   = 1'b1;
        complete_rob_idx[l] = idx;
        complete_taken[l]   = tk;
        complete_target[l]  = tgt;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        #12;
        checks++; if (rob_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %0b expected 1", rob_empty); end
        checks++; if (rob_retire !== 2'b00) begin errors++; $display("FAIL reset_retire: got %0b expected 00", rob_retire); end
        checks++; if (squash !== 1'b0 || halt_out !== 1'b0) begin errors++; $display("FAIL reset_squash_halt: got %0b%0b expected 00", squash, halt_out); end
        checks++; if (squash_PC !== 32'h0) begin errors++; $display("FAIL reset_squash_pc: got %0h expected 0", squash_PC); end
        checks++; if (dispatch_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b expected 1", dispatch_ready); end
        @(negedge clock);
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        set_lane(0, 5'd3, 6'd40, 1'b1, 32'h1000, 1'b0, 1'b0, 32'h0, 1'b0);
        set_lane(1, 5'd4, 6'd41, 1'b1, 32'h1004, 1'b0, 1'b0, 32'h0, 1'b0);
        checks++; if (dispatch_rob_idx[0] !== 5'd0 || dispatch_rob_idx[1] !== 5'd1) begin errors++; $display("FAIL basic_tags: got %0d,%0d expected 0,1", dispatch_rob_idx[0], dispatch_rob_idx[1]); end
        tick();
        clear_inputs();
        checks++; if (rob_empty !== 1'b0 || rob_retire !== 2'b00) begin errors++; $display("FAIL basic_pending: got empty=%0b retire=%0b expected 0,00", rob_empty, rob_retire); end
        set_complete(0, 5'd0, 1'b0, 32'h0);
        set_complete(1, 5'd1, 1'b0, 32'h0);
        tick();
        clear_inputs();
        checks++; if (rob_retire !== 2'b11) begin errors++; $display("FAIL basic_retire: got %0b expected 11", rob_retire); end
        checks++; if (ARCH_ARF_idx[0] !== 5'd3 || ARCH_ARF_idx[1] !== 5'd4) begin errors++; $display("FAIL basic_arn: got %0d,%0d expected 3,4", ARCH_ARF_idx[0], ARCH_ARF_idx[1]); end
        checks++; if (ARCH_PRF_idx[0] !== 6'd40 || dest_PRN_out[1] !== 6'd41) begin errors++; $display("FAIL basic_prn: got %0d,%0d expected 40,41", ARCH_PRF_idx[0], dest_PRN_out[1]); end
        checks++; if (retired !== 2'b11 || valid_update !== 2'b00) begin errors++; $display("FAIL basic_retired: got %0b/%0b expected 11/00", retired, valid_update); end
        tick();
        checks++; if (rob_empty !== 1'b1) begin errors++; $display("FAIL basic_empty_after: got %0b expected 1", rob_empty); end
        checks++; if (dispatch_rob_idx[0] !== 5'd2) begin errors++; $display("FAIL basic_tail: got %0d expected 2", dispatch_rob_idx[0]); end
    endtask

    task automatic test_out_of_order();
        set_lane(0, 5'd10, 6'd20, 1'b1, 32'h2000, 1'b0, 1'b0, 32'h0, 1'b0);
        set_lane(1, 5'd11, 6'd21, 1'b1, 32'h2004, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        clear_inputs();
        set_complete(0, 5'd3, 1'b0, 32'h0);
        tick();
        clear_inputs();
        checks++; if (rob_retire !== 2'b00) begin errors++; $display("FAIL ooo_blocked: got %0b expected 00", rob_retire); end
        tick();
        checks++; if (rob_retire !== 2'b00) begin errors++; $display("FAIL ooo_still_blocked: got %0b expected 00", rob_retire); end
        set_complete(0, 5'd2, 1'b0, 32'h0);
        tick();
        clear_inputs();
        checks++; if (rob_retire !== 2'b11) begin errors++; $display("FAIL ooo_retire: got %0b expected 11", rob_retire); end
        checks++; if (ARCH_ARF_idx[0] !== 5'd10 || ARCH_ARF_idx[1] !== 5'd11) begin errors++; $display("FAIL ooo_order: got %0d,%0d expected 10,11", ARCH_ARF_idx[0], ARCH_ARF_idx[1]); end
        tick();
        checks++; if (rob_empty !== 1'b1) begin errors++; $display("FAIL ooo_empty: got %0b expected 1", rob_empty); end
    endtask

    task automatic test_full_wrap();
        logic [ROB_W-1:0] exp_tail;
        logic [ROB_W-1:0] t;
        int               cyc;
        exp_tail = 5'd4;
        set_lane(0, 5'd1, 6'd1, 1'b1, 32'h3000, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        clear_inputs();
        exp_tail = exp_tail + 5'd1;
        for (int k = 0; k < 15; k++) begin
            set_lane(0, 5'd2, 6'd2, 1'b1, 32'h3100, 1'b0, 1'b0, 32'h0, 1'b0);
            set_lane(1, 5'd3, 6'd3, 1'b1, 32'h3104, 1'b0, 1'b0, 32'h0, 1'b0);
            if (k == 13) begin
                checks++; if (dispatch_rob_idx[0] !== 5'd31 || dispatch_rob_idx[1] !== 5'd0) begin errors++; $display("FAIL wrap_tags: got %0d,%0d expected 31,0", dispatch_rob_idx[0], dispatch_rob_idx[1]); end
            end
            if (k == 14) begin
                checks++; if (dispatch_ready !== 1'b1) begin errors++; $display("FAIL ready_at_29: got %0b expected 1", dispatch_ready); end
            end
            tick();
            clear_inputs();
            exp_tail = exp_tail + 5'd2;
        end
        checks++; if (dispatch_ready !== 1'b0) begin errors++; $display("FAIL full_not_ready: got %0b expected 0", dispatch_ready); end
        checks++; if (dispatch_rob_idx[0] !== exp_tail) begin errors++; $display("FAIL full_tail: got %0d expected %0d", dispatch_rob_idx[0], exp_tail); end
        set_lane(0, 5'd9, 6'd9, 1'b1, 32'h3200, 1'b0, 1'b0, 32'h0, 1'b0);
        set_lane(1, 5'd9, 6'd9, 1'b1, 32'h3204, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        clear_inputs();
        checks++; if (dispatch_rob_idx[0] !== exp_tail) begin errors++; $display("FAIL full_ignored: got %0d expected %0d", dispatch_rob_idx[0], exp_tail); end
        set_complete(0, 5'd4, 1'b0, 32'h0);
        set_complete(1, 5'd5, 1'b0, 32'h0);
        tick();
        clear_inputs();
        checks++; if (rob_retire !== 2'b11) begin errors++; $display("FAIL full_retire: got %0b expected 11", rob_retire); end
        tick();
        checks++; if (dispatch_ready !== 1'b1) begin errors++; $display("FAIL ready_after_retire: got %0b expected 1", dispatch_ready); end
        set_lane(0, 5'd6, 6'd6, 1'b1, 32'h3300, 1'b0, 1'b0, 32'h0, 1'b0);
        set_lane(1, 5'd7, 6'd7, 1'b1, 32'h3304, 1'b0, 1'b0, 32'h0, 1'b0);
        checks++; if (dispatch_rob_idx[0] !== 5'd3 || dispatch_rob_idx[1] !== 5'd4) begin errors++; $display("FAIL wrap_reuse_tags: got %0d,%0d expected 3,4", dispatch_rob_idx[0], dispatch_rob_idx[1]); end
        tick();
        clear_inputs();
        // Drain: complete every tag from 6 upward, two per cycle.
        for (int k = 0; k < 16; k++) begin
            t = 5'(6 + 2 * k);
            set_complete(0, t, 1'b0, 32'h0);
            set_complete(1, t + 5'd1, 1'b0, 32'h0);
            tick();
            clear_inputs();
        end
        cyc = 0;
        while (!rob_empty && cyc < 20) begin
            tick();
            cyc++;
        end
        checks++; if (rob_empty !== 1'b1) begin errors++; $display("FAIL drain_timeout: got empty=%0b expected 1", rob_empty); end
        checks++; if (dispatch_rob_idx[0] !== 5'd5) begin errors++; $display("FAIL drain_tail: got %0d expected 5", dispatch_rob_idx[0]); end
    endtask

    task automatic test_mispredict();
        set_lane(0, 5'd1, 6'd30, 1'b1, 32'h100, 1'b1, 1'b0, 32'h104, 1'b0);
        set_lane(1, 5'd8, 6'd31, 1'b1, 32'h104, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        clear_inputs();
        set_complete(0, 5'd5, 1'b1, 32'h200);
        set_complete(1, 5'd6, 1'b0, 32'h0);
        tick();
        clear_inputs();
        checks++; if (rob_retire !== 2'b01) begin errors++; $display("FAIL br_retire_alone: got %0b expected 01", rob_retire); end
        checks++; if (valid_update !== 2'b01 || retired !== 2'b01) begin errors++; $display("FAIL br_updates: got %0b/%0b expected 01/01", valid_update, retired); end
        checks++; if (PC_update[0] !== 32'h100 || direction_update[0] !== 1'b1 || target_update[0] !== 32'h200) begin errors++; $display("FAIL br_pred_update: got %0h,%0b,%0h expected 100,1,200", PC_update[0], direction_update[0], target_update[0]); end
        checks++; if (squash !== 1'b0) begin errors++; $display("FAIL br_squash_early: got %0b expected 0", squash); end
        tick();
        checks++; if (squash !== 1'b1 || squash_PC !== 32'h200) begin errors++; $display("FAIL br_squash: got %0b,%0h expected 1,200", squash, squash_PC); end
        checks++; if (rob_empty !== 1'b1 || dispatch_ready !== 1'b0) begin errors++; $display("FAIL br_flush: got empty=%0b ready=%0b expected 1,0", rob_empty, dispatch_ready); end
        set_lane(0, 5'd2, 6'd2, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 1'b0);
        set_complete(0, 5'd0, 1'b0, 32'h0);
        tick();
        clear_inputs();
        checks++; if (squash !== 1'b0 || rob_empty !== 1'b1 || dispatch_rob_idx[0] !== 5'd0) begin errors++; $display("FAIL br_after_squash: got sq=%0b empty=%0b tail=%0d expected 0,1,0", squash, rob_empty, dispatch_rob_idx[0]); end
    endtask

    task automatic test_halt();
        set_lane(0, 5'd0, 6'd0, 1'b0, 32'h400, 1'b0, 1'b0, 32'h0, 1'b1);
        set_lane(1, 5'd7, 6'd50, 1'b1, 32'h404, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        clear_inputs();
        set_complete(0, 5'd0, 1'b0, 32'h0);
        set_complete(1, 5'd1, 1'b0, 32'h0);
        tick();
        clear_inputs();
        checks++; if (rob_retire !== 2'b01) begin errors++; $display("FAIL halt_retire: got %0b expected 01", rob_retire); end
        tick();
        checks++; if (halt_out !== 1'b1 || dispatch_ready !== 1'b0) begin errors++; $display("FAIL halt_set: got halt=%0b ready=%0b expected 1,0", halt_out, dispatch_ready); end
        checks++; if (rob_retire !== 2'b00) begin errors++; $display("FAIL halt_no_retire: got %0b expected 00", rob_retire); end
        tick();
        checks++; if (rob_retire !== 2'b00 || halt_out !== 1'b1 || rob_empty !== 1'b0) begin errors++; $display("FAIL halt_sticky: got retire=%0b halt=%0b empty=%0b expected 00,1,0", rob_retire, halt_out, rob_empty); end
    endtask

    task automatic test_reset_mid();
        reset = 1'b1;
        #1;
        reset = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            set_lane(0, 5'(k + 1), 6'(k + 1), 1'b1, 32'h500, 1'b0, 1'b0, 32'h0, 1'b0);
            set_lane(1, 5'(k + 9), 6'(k + 9), 1'b1, 32'h504, 1'b0, 1'b0, 32'h0, 1'b0);
            tick();
            clear_inputs();
        end
        set_complete(0, 5'd0, 1'b0, 32'h0);
        set_complete(1, 5'd1, 1'b0, 32'h0);
        tick();
        clear_inputs();
        checks++; if (rob_retire !== 2'b11 || ARCH_ARF_idx[0] !== 5'd1) begin errors++; $display("FAIL mid_before: got %0b,%0d expected 11,1", rob_retire, ARCH_ARF_idx[0]); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (rob_retire !== 2'b00 || retired !== 2'b00 || valid_update !== 2'b00) begin errors++; $display("FAIL mid_reset_retire: got %0b/%0b/%0b expected 00/00/00", rob_retire, retired, valid_update); end
        checks++; if (ARCH_ARF_idx !== 10'h0 || rob_empty !== 1'b1) begin errors++; $display("FAIL mid_reset_empty: got arn=%0h empty=%0b expected 0,1", ARCH_ARF_idx, rob_empty); end
        checks++; if (squash !== 1'b0 || halt_out !== 1'b0) begin errors++; $display("FAIL mid_reset_flags: got %0b%0b expected 00", squash, halt_out); end
        @(negedge clock);
        reset = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_out_of_order();
        test_full_wrap();
        test_mispredict();
        test_halt();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
